// File: rtl/memwb_skid_reg_if.sv
// MEM/WB boundary handshake bundle: MEM-side input channel and write-back-side head channel.
// The block under the slave modport accepts entries and presents its head entry.
interface memwb_skid_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_wb;
    logic [REG_AW-1:0] in_rd;
    logic [DATA_W-1:0] in_mem;
    logic [DATA_W-1:0] in_alu;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_wb;
    logic [REG_AW-1:0] out_rd;
    logic [DATA_W-1:0] out_mem;
    logic [DATA_W-1:0] out_alu;

    modport master (
        output in_valid, in_wb, in_rd, in_mem, in_alu, out_ready,
        input  in_ready, out_valid, out_wb, out_rd, out_mem, out_alu
    );

    modport slave (
        input  in_valid, in_wb, in_rd, in_mem, in_alu, out_ready,
        output in_ready, out_valid, out_wb, out_rd, out_mem, out_alu
    );
endinterface

// File: rtl/memwb_skid_reg.sv
// MEM/WB pipeline register with a 2-entry skid buffer, registered in_ready,
// write-back data select, $zero-suppressed write strobe and a retired-write counter.
module memwb_skid_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    memwb_skid_reg_if.slave    bus,
    output logic               wb_en,
    output logic [DATA_W-1:0]  wb_data,
    output logic [CNT_W-1:0]   retired
);
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_in_ready;

    logic [CTRL_W-1:0] r_head_wb_p0;
    logic [REG_AW-1:0] r_head_rd_p0;
    logic [DATA_W-1:0] r_head_mem_p0;
    logic [DATA_W-1:0] r_head_alu_p0;
    logic [CTRL_W-1:0] r_skid_wb_p0;
    logic [REG_AW-1:0] r_skid_rd_p0;
    logic [DATA_W-1:0] r_skid_mem_p0;
    logic [DATA_W-1:0] r_skid_alu_p0;
    logic [CNT_W-1:0]  r_retired;

    logic              w_acc;
    logic              w_rel;
    logic              w_out_valid;
    logic              w_head_from_in;
    logic              w_head_from_skid;
    logic              w_skid_from_in;
    logic              w_wb_en;

    assign w_out_valid = (r_state != S_EMPTY);
    assign w_acc       = bus.in_valid & r_in_ready;
    assign w_rel       = w_out_valid & bus.out_ready;

    // in_ready is registered from the next state, so out_ready never reaches it combinationally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != S_FULL);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_acc) w_state_nxt = S_ONE;
                S_ONE: begin
                    if (w_acc && !w_rel)      w_state_nxt = S_FULL;
                    else if (!w_acc && w_rel) w_state_nxt = S_EMPTY;
                end
                S_FULL:  if (w_rel) w_state_nxt = S_ONE;
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        w_head_from_in   = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;
        if (!flush) begin
            case (r_state)
                S_EMPTY: w_head_from_in = w_acc;
                S_ONE: begin
                    w_head_from_in = w_acc & w_rel;
                    w_skid_from_in = w_acc & ~w_rel;
                end
                S_FULL:  w_head_from_skid = w_rel;
                default: ;
            endcase
        end
    end

    // ---- stage p0: head and skid payload registers ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head_wb_p0  <= '0;
            r_head_rd_p0  <= '0;
            r_head_mem_p0 <= '0;
            r_head_alu_p0 <= '0;
            r_skid_wb_p0  <= '0;
            r_skid_rd_p0  <= '0;
            r_skid_mem_p0 <= '0;
            r_skid_alu_p0 <= '0;
        end else begin
            if (w_head_from_in) begin
                r_head_wb_p0  <= bus.in_wb;
                r_head_rd_p0  <= bus.in_rd;
                r_head_mem_p0 <= bus.in_mem;
                r_head_alu_p0 <= bus.in_alu;
            end else if (w_head_from_skid) begin
                r_head_wb_p0  <= r_skid_wb_p0;
                r_head_rd_p0  <= r_skid_rd_p0;
                r_head_mem_p0 <= r_skid_mem_p0;
                r_head_alu_p0 <= r_skid_alu_p0;
            end
            if (w_skid_from_in) begin
                r_skid_wb_p0  <= bus.in_wb;
                r_skid_rd_p0  <= bus.in_rd;
                r_skid_mem_p0 <= bus.in_mem;
                r_skid_alu_p0 <= bus.in_alu;
            end
        end
    end

    // A flushing head still completes its write when released in the same cycle
    assign w_wb_en = w_rel & r_head_wb_p0[0] & (r_head_rd_p0 != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= '0;
        end else if (w_wb_en) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_wb    = r_head_wb_p0;
    assign bus.out_rd    = r_head_rd_p0;
    assign bus.out_mem   = r_head_mem_p0;
    assign bus.out_alu   = r_head_alu_p0;
    assign wb_en         = w_wb_en;
    assign wb_data       = r_head_wb_p0[1] ? r_head_mem_p0 : r_head_alu_p0;
    assign retired       = r_retired;
endmodule

// File: tb/tb_memwb_skid_reg.sv
// Directed bench for memwb_skid_reg: a default-width instance plus a CNT_W=2 instance
// sharing one stimulus so the counter wrap can be observed.
module tb_memwb_skid_reg;
    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [1:0]  in_wb;
    logic [4:0]  in_rd;
    logic [31:0] in_mem;
    logic [31:0] in_alu;
    logic        out_ready;

    logic        wb_en_a, wb_en_b;
    logic [31:0] wb_data_a, wb_data_b;
    logic [15:0] retired_a;
    logic [1:0]  retired_b;

    int checks = 0;
    int errors = 0;

    memwb_skid_reg_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(2)) bus_a ();
    memwb_skid_reg_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(2)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_wb     = in_wb;
    assign bus_a.in_rd     = in_rd;
    assign bus_a.in_mem    = in_mem;
    assign bus_a.in_alu    = in_alu;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_wb     = in_wb;
    assign bus_b.in_rd     = in_rd;
    assign bus_b.in_mem    = in_mem;
    assign bus_b.in_alu    = in_alu;
    assign bus_b.out_ready = out_ready;

    memwb_skid_reg #(.DATA_W(32), .REG_AW(5), .CTRL_W(2), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus_a),
        .wb_en(wb_en_a), .wb_data(wb_data_a), .retired(retired_a)
    );

    memwb_skid_reg #(.DATA_W(32), .REG_AW(5), .CTRL_W(2), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus_b),
        .wb_en(wb_en_b), .wb_data(wb_data_b), .retired(retired_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [1:0] wb, input logic [4:0] rd,
                         input logic [31:0] mem, input logic [31:0] alu);
        in_valid = v;
        in_wb    = wb;
        in_rd    = rd;
        in_mem   = mem;
        in_alu   = alu;
    endtask

    logic [1:0] wrap_exp [5];

    initial begin
        wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        #1;
        chk("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus_a.in_ready),  64'd1);
        chk("rst_wb_en",     64'(wb_en_a),         64'd0);
        chk("rst_retired",   64'(retired_a),       64'd0);
        chk("rst_wb_data",   64'(wb_data_a),       64'd0);
        chk("rst_out_rd",    64'(bus_a.out_rd),    64'd0);
        #11 reset = 1'b0;

        // single writing entry streamed with out_ready high
        out_ready = 1'b1;
        drive(1'b1, 2'b01, 5'd3, 32'h0, 32'h11);
        tick();
        in_valid = 1'b0;
        #1;
        chk("s1_out_valid", 64'(bus_a.out_valid), 64'd1);
        chk("s1_wb_en",     64'(wb_en_a),         64'd1);
        chk("s1_wb_data",   64'(wb_data_a),       64'h11);
        chk("s1_in_ready",  64'(bus_a.in_ready),  64'd1);
        tick();
        chk("s1_retired",   64'(retired_a),       64'd1);
        chk("s1_empty",     64'(bus_a.out_valid), 64'd0);
        chk("s1_in_ready2", 64'(bus_a.in_ready),  64'd1);

        // fill to FULL, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 5'd4, 32'h0, 32'hA);
        tick();
        chk("ab_in_ready1", 64'(bus_a.in_ready), 64'd1);
        chk("ab_head_a1",   64'(bus_a.out_alu),  64'hA);
        drive(1'b1, 2'b01, 5'd5, 32'h0, 32'hB);
        tick();
        in_valid = 1'b0;
        chk("ab_full_rdy",  64'(bus_a.in_ready), 64'd0);
        chk("ab_head_a2",   64'(bus_a.out_alu),  64'hA);
        chk("ab_hold_wben", 64'(wb_en_a),        64'd0);
        out_ready = 1'b1;
        #1;
        chk("ab_a_wb_en",   64'(wb_en_a),        64'd1);
        chk("ab_a_data",    64'(wb_data_a),      64'hA);
        tick();
        chk("ab_head_b",    64'(bus_a.out_alu),  64'hB);
        chk("ab_rd_b",      64'(bus_a.out_rd),   64'd5);
        chk("ab_ready_ret", 64'(bus_a.in_ready), 64'd1);
        chk("ab_retired2",  64'(retired_a),      64'd2);
        tick();
        chk("ab_retired3",  64'(retired_a),      64'd3);
        chk("ab_empty",     64'(bus_a.out_valid), 64'd0);

        // MemToReg select, then rd=0 suppression
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 5'd7, 32'hDEAD, 32'hBEEF);
        tick();
        in_valid = 1'b0;
        chk("m2r_wb_data", 64'(wb_data_a), 64'hDEAD);
        out_ready = 1'b1;
        #1;
        chk("m2r_wb_en",   64'(wb_en_a),   64'd1);
        tick();
        chk("m2r_retired", 64'(retired_a), 64'd4);
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 5'd0, 32'h0, 32'h55);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rd0_valid",   64'(bus_a.out_valid), 64'd1);
        chk("rd0_wb_en",   64'(wb_en_a),         64'd0);
        chk("rd0_wb_data", 64'(wb_data_a),       64'h55);
        tick();
        chk("rd0_retired", 64'(retired_a),       64'd4);

        // flush while FULL with the head released on the same edge
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 5'd1, 32'h0, 32'hC);
        tick();
        drive(1'b1, 2'b01, 5'd2, 32'h0, 32'hD);
        tick();
        drive(1'b1, 2'b01, 5'd6, 32'h0, 32'hE);
        out_ready = 1'b1;
        flush = 1'b1;
        #1;
        chk("fl_wb_en",    64'(wb_en_a),   64'd1);
        chk("fl_wb_data",  64'(wb_data_a), 64'hC);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("fl_in_ready",  64'(bus_a.in_ready),  64'd1);
        chk("fl_retired",   64'(retired_a),       64'd5);
        tick();
        chk("fl_skid_gone", 64'(bus_a.out_valid), 64'd0);

        // flush discards an input offered while in_ready=1
        drive(1'b1, 2'b01, 5'd9, 32'h0, 32'h77);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_in_drop",   64'(bus_a.out_valid), 64'd0);
        chk("fl_in_retire", 64'(retired_a),       64'd5);

        // asynchronous reset while FULL
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 5'd1, 32'h0, 32'h21);
        tick();
        drive(1'b1, 2'b01, 5'd2, 32'h0, 32'h22);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("ar_pre_full", 64'(bus_a.in_ready), 64'd0);
        #1 reset = 1'b1;
        #1;
        chk("ar_out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("ar_wb_en",     64'(wb_en_a),         64'd0);
        chk("ar_retired",   64'(retired_a),       64'd0);
        chk("ar_out_alu",   64'(bus_a.out_alu),   64'd0);
        chk("ar_in_ready",  64'(bus_a.in_ready),  64'd1);
        #2 reset = 1'b0;
        tick();
        chk("ar_post_idle", 64'(bus_a.out_valid), 64'd0);

        // counter wrap on the CNT_W=2 instance
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b01, 5'd1, 32'h0, 32'(i));
            tick();
            in_valid = 1'b0;
            tick();
            chk($sformatf("wrap_b_%0d", i), 64'(retired_b), 64'(wrap_exp[i]));
        end
        chk("wrap_a_total", 64'(retired_a), 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/memwb_skid_reg.md
Name: memwb_skid_reg

Overview:
- Parametrised MEM/WB pipeline boundary register with a valid/ready handshake and a 2-entry skid buffer.
- MEM can keep issuing while the write-back port stalls; no combinational ready path crosses the boundary.
- Adds flush, write-back data selection, a register-write enable with $zero suppression, and a retired-write counter.
- Sits between the MEM stage and the register-file write port.

Parameters:
- DATA_W, 32: width of the memory-read and ALU-result datapaths.
- REG_AW, 5: destination register address width.
- CTRL_W, 2: width of the WB control field; bit0 = RegWrite, bit1 = MemToReg, upper bits are carried through unchanged.
- CNT_W, 16: width of the retired-write counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  MEM stage presents an entry.
- in_ready  out  1  block can accept an entry; registered.
- in_wb  in  CTRL_W  WB control field.
- in_rd  in  REG_AW  destination register.
- in_mem  in  DATA_W  memory read data.
- in_alu  in  DATA_W  ALU result.
- out_valid  out  1  head entry valid.
- out_ready  in  1  write-back port accepts the head entry.
- out_wb  out  CTRL_W  head entry WB field.
- out_rd  out  REG_AW  head entry destination register.
- out_mem  out  DATA_W  head entry memory data.
- out_alu  out  DATA_W  head entry ALU result.
- wb_en  out  1  register-file write strobe.
- wb_data  out  DATA_W  selected write-back data.
- retired  out  CNT_W  count of performed register writes.

Behaviour:
- Storage: head register (drives out_*) and skid register. Occupancy state is EMPTY (0), ONE (head only) or FULL (head + skid).
- Accept: acc = in_valid & in_ready. Release: rel = out_valid & out_ready.
- in_ready = (state != FULL). It is a flop output, with no combinational path from out_ready.
- EMPTY: acc loads head -> ONE.
- ONE:
  - acc & rel: head <= input, stay ONE.
  - acc & !rel: skid <= input -> FULL.
  - !acc & rel: -> EMPTY.
- FULL: acc is impossible. rel: head <= skid -> ONE. Otherwise hold.
- Latency: an input accepted at edge N is visible on out_* after edge N when entering EMPTY/ONE.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- out_valid = (state != EMPTY). Payload outputs are don't-care when out_valid=0 but hold their last loaded value. Payload registers are not cleared on a release.
- wb_en = rel & out_wb[0] & (out_rd != 0). This is combinational from the head entry and out_ready.
- wb_data = out_wb[1] ? out_mem : out_alu. It is combinational and valid whenever out_valid=1.
- retired increments by 1 on every cycle with wb_en=1. It wraps from 2^CNT_W-1 to 0. Entries with RegWrite=0 or rd=0 do not count.
- flush (synchronous, highest priority):
  - Next state is EMPTY and in_ready=1 next cycle.
  - An input offered in the same cycle is discarded, even if in_ready=1. The retired counter does not count it.
  - The head entry still completes that cycle if out_ready=1: wb_en asserts and retired counts.
  - The skid entry is discarded.
- reset (asynchronous, active-high), on assertion:
  - State EMPTY, out_valid=0, in_ready=1.
  - All payload registers 0: out_wb, out_rd, out_mem, out_alu, so wb_data=0.
  - retired=0, wb_en=0.
- Reset mid-operation discards both entries without any write strobe. Operation resumes on the first clk edge after deassertion.
- No reset value depends on parameters other than width.

Test Plan:
- Reset, then stream in_wb=2'b01, rd=3, alu=0x11 with out_ready=1 -> out_valid next cycle, wb_en=1, wb_data=0x11, retired=1. in_ready stays 1 throughout.
- Back-to-back accepts A(alu=0xA), B(alu=0xB) with out_ready=0:
  - After the 2nd edge: state FULL, in_ready=0, head=A.
  - Raise out_ready: A retires, then B, in order. in_ready returns to 1 after A's release edge.
- MemToReg entry wb=2'b11, mem=0xDEAD, alu=0xBEEF -> wb_data=0xDEAD. Entry wb=2'b01, rd=0 -> wb_en=0 on release and retired unchanged.
- FULL with out_ready=1 and flush=1 on one edge -> head retires (wb_en=1, retired+1), skid dropped. The simultaneous in_valid entry is dropped. Next cycle out_valid=0, in_ready=1.
- Assert reset asynchronously mid-clock while FULL -> out_valid, wb_en, retired and out_alu go to 0 immediately, in_ready=1 without a clock edge.
- CNT_W=2: retire 5 writing entries -> retired sequence 1,2,3,0,1.
